// File: rtl/vector_fetch_sequencer.sv
// Fetches one weight vector and one feature vector, one word-wide beat per cycle
// from two synchronous read ports. Assembles both into full-width vectors and presents
// the pair downstream under a valid/ready handshake. One job is in flight at a time.
module vector_fetch_sequencer #(
    parameter int unsigned NUM_ELEM = 96,
    parameter int unsigned ELEM_W   = 5,
    parameter int unsigned LANES    = 8,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            w_base,
    input  logic [ADDR_W-1:0]            f_base,
    output logic                         busy,
    output logic                         done,
    output logic                         w_rd_en,
    output logic [ADDR_W-1:0]            w_addr,
    input  logic [LANES*ELEM_W-1:0]      w_rdata,
    output logic                         f_rd_en,
    output logic [ADDR_W-1:0]            f_addr,
    input  logic [LANES*ELEM_W-1:0]      f_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_ELEM*ELEM_W-1:0]   weight_vec,
    output logic [NUM_ELEM*ELEM_W-1:0]   feature_vec
);

    localparam int unsigned NUM_BEATS = NUM_ELEM / LANES;
    localparam int unsigned WORD_W    = LANES * ELEM_W;
    localparam int unsigned VEC_W     = NUM_ELEM * ELEM_W;
    localparam int unsigned BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS + 1) : 1;

    if (NUM_ELEM % LANES != 0) begin : g_bad_lanes
        $error("NUM_ELEM must be a multiple of LANES");
    end

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StHold} state_e;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q;
    logic [ADDR_W-1:0]   w_base_q, f_base_q;
    logic                cap_vld_q;
    logic [BEAT_W-1:0]   cap_beat_q;
    logic                done_q;
    logic [VEC_W-1:0]    weight_q, feature_q;

    // State register; reset abandons any job in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state and control outputs, all decoded from the current state.
    always_comb begin
        state_d   = state_q;
        busy      = (state_q != StIdle);
        out_valid = (state_q == StHold);
        w_rd_en   = 1'b0;
        f_rd_en   = 1'b0;
        w_addr    = '0;
        f_addr    = '0;
        case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                w_rd_en = 1'b1;
                f_rd_en = 1'b1;
                // Both ports share the beat index; the sum wraps at the address width.
                w_addr  = w_base_q + ADDR_W'(beat_q);
                f_addr  = f_base_q + ADDR_W'(beat_q);
                if (beat_q == BEAT_W'(NUM_BEATS - 1)) state_d = StDrain;
            end
            StDrain: begin
                state_d = StHold;
            end
            StHold: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Beat counter, latched bases, read-return tracking and the done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_q     <= '0;
            w_base_q   <= '0;
            f_base_q   <= '0;
            cap_vld_q  <= 1'b0;
            cap_beat_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= (state_q == StHold) && out_ready;
            // Read data arrives one cycle after issue, so remember which beat it belongs to.
            cap_vld_q  <= (state_q == StFetch);
            cap_beat_q <= beat_q;
            if (state_q == StIdle && start) begin
                w_base_q <= w_base;
                f_base_q <= f_base;
                beat_q   <= '0;
            end else if (state_q == StFetch) begin
                beat_q   <= beat_q + BEAT_W'(1);
            end
        end
    end

    // Vector assembly: returned word for beat k fills elements k*LANES .. k*LANES+LANES-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weight_q  <= '0;
            feature_q <= '0;
        end else if (cap_vld_q) begin
            for (int b = 0; b < int'(NUM_BEATS); b++) begin
                if (cap_beat_q == BEAT_W'(b)) begin
                    weight_q[b*WORD_W +: WORD_W]  <= w_rdata;
                    feature_q[b*WORD_W +: WORD_W] <= f_rdata;
                end
            end
        end
    end

    assign done        = done_q;
    assign weight_vec  = weight_q;
    assign feature_vec = feature_q;

endmodule
